// File: rtl/obi_mem_sbr.sv
// obi_mem_sbr: OBI subordinate backed by a word-addressed memory.
// Every granted request pushes one response into an in-order FIFO. The head
// of that FIFO is presented on the response channel. gnt_stall_i and
// rsp_stall_i let a bench inject grant and response backpressure.
module obi_mem_sbr #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumWords       = 256,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_i,
  output logic                                  gnt_o,
  input  logic [AddrWidth-1:0]                  addr_i,
  input  logic                                  we_i,
  input  logic [DataWidth/8-1:0]                be_i,
  input  logic [DataWidth-1:0]                  wdata_i,
  output logic                                  rvalid_o,
  input  logic                                  rready_i,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  err_o,
  input  logic                                  gnt_stall_i,
  input  logic                                  rsp_stall_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned OffWidth = $clog2(BeWidth);
  localparam int unsigned IdxWidth = $clog2(NumWords);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxOutstanding - 1);

  // Storage
  logic [DataWidth-1:0] mem_q [NumWords];

  logic [DataWidth-1:0] fifo_data_q [MaxOutstanding];
  logic                 fifo_err_q  [MaxOutstanding];

  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 presented_q, presented_d;

  // Address decode
  logic [IdxWidth-1:0]  word_idx;
  logic [AddrWidth-1:0] addr_hi;
  logic                 out_of_range;

  // Handshake and response bookkeeping
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 mem_wr_en;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] push_data;
  logic                 push_err;

  // Ring pointer increment. It also handles depths that are not a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrLast) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  // The word index sits directly above the byte-offset bits. Any set bit
  // above the index field addresses memory that does not exist.
  assign word_idx     = addr_i[OffWidth +: IdxWidth];
  assign addr_hi      = addr_i >> (OffWidth + IdxWidth);
  assign out_of_range = |addr_hi;

  assign fifo_empty = (cnt_q == '0);

  // Grant ignores rready_i and any pop in the same cycle. A full FIFO blocks
  // the grant until the pop has been registered.
  assign gnt_o = req_i & ~rst_i & ~gnt_stall_i & (cnt_q < CntMax);
  assign push  = req_i & gnt_o;

  // Once the head is on the bus, the presented flag holds it there.
  // A later rsp_stall_i therefore cannot withdraw a response that is already showing.
  assign rvalid_o = ~rst_i & ~fifo_empty & (presented_q | ~rsp_stall_i);
  assign pop      = rvalid_o & rready_i;

  assign rdata_o       = fifo_empty ? '0   : fifo_data_q[rptr_q];
  assign err_o         = fifo_empty ? 1'b0 : fifo_err_q[rptr_q];
  assign outstanding_o = cnt_q;

  // Reads sample the array in the grant cycle. A write granted one cycle
  // earlier has already been committed.
  assign rd_word   = mem_q[word_idx];
  assign mem_wr_en = push & we_i & ~out_of_range;
  assign push_data = (we_i | out_of_range) ? '0 : rd_word;
  assign push_err  = out_of_range;

  // Next-state logic for the FIFO pointers, the occupancy count and the presented flag
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    presented_d = presented_q;

    if (push) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (pop) begin
      presented_d = 1'b0;
    end else if (rvalid_o && !rready_i) begin
      presented_d = 1'b1;
    end
  end

  // FIFO control registers, cleared by the synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      presented_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      presented_q <= presented_d;
    end
  end

  // FIFO payload. It needs no reset because cnt_q guards every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wptr_q] <= push_data;
      fifo_err_q[wptr_q]  <= push_err;
    end
  end

  // Memory array. Its contents are not reset, so they survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_wr_en) begin
      for (int k = 0; k < BeWidth; k++) begin
        if (be_i[k]) begin
          mem_q[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

endmodule
